tbird_seq: RTL and testbench
============================

Name: tbird_seq

Overview:
Frame-synchronous sequencer for the tail-light display: converts left/right/hazard switch requests into the 22-bit active-low lamp pattern consumed by the VGA bit generator. Advances one animation step every STEP_FRAMES video frames. Pattern changes only on a frame boundary, so no frame shows a mid-frame change. Sits between the board switches/VGA timing block and the pixel colour generator.

Parameters:
STEP_FRAMES, 15, frames per animation step (>=1)
CNT_BITS, 6, width of frame counter (must hold STEP_FRAMES-1)

Ports:
clk  in  1  pixel/system clock
clr  in  1  asynchronous active-high reset
left_sw  in  1  left-turn request, asynchronous switch
right_sw  in  1  right-turn request, asynchronous switch
haz_sw  in  1  hazard request, asynchronous switch
frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank
pattern  out  22  active-low lamp code to bit generator (registered)
step  out  1  one-cycle pulse in the cycle pattern updates
state_dbg  out  4  current state encoding, for LEDs/debug

Behaviour:
- Reset (async, clr=1): state OFF, pattern=22'h3FFFFF, step=0, frame counter=0, synchronizer flops=0.
- Switches pass through 2-flop synchronizers; FSM uses synced values (2-cycle input latency).
- Pattern codes (package constants): O=3FFFFF, H=000000, L1=3FE7FF, L2=3F07FF, L3=3807FF, L4=2007FF, L5=0007FF, R1=3FF9FF, R2=3FF83F, R3=3FF807, R4=3FF801, R5=3FF800 (hex).
- Tick: on frame_start, if counter==STEP_FRAMES-1 then counter<=0 and tick=1, else counter+1. No counting without frame_start. STEP_FRAMES=1 gives a tick every frame_start.
- FSM advances only on tick. In the tick cycle, state and pattern update, and step pulses in the same cycle.
- Request decode at tick: haz, or left and right together -> HAZ. Else left -> LEFT. Else right -> RIGHT. Else NONE.
- States: OFF, L1..L5, R1..R5, HON, HOFF (13; state_dbg encodes OFF=0, L1..L5=1..5, R1..R5=6..10, HON=11, HOFF=12).
- OFF: HAZ->HON, LEFT->L1, RIGHT->R1, NONE->OFF.
- Ln (n<5): LEFT->L(n+1). Any other request->OFF.
- L5: always ->OFF (one dark step between sweeps).
- Rn: mirror of Ln with RIGHT. R5 always ->OFF.
- HON: HAZ->HOFF, else OFF. HOFF: HAZ->HON, else OFF.
- Priority: a direction change or hazard mid-sweep always passes through OFF for one step before the new sequence begins. Exception: hazard from OFF enters HON directly.
- pattern = code of the next state: OFF and HOFF->O, HON->H, Ln/Rn->matching code.
- Simultaneous frame_start and clr: clr wins.
- Requests asserted and released between ticks are ignored; only the value sampled at tick matters.

Decomposition:
- tbird_pkg: 22-bit pattern constants (O, H, L1-L5, R1-R5), state enum/encoding, request enum.
- Sub-module step_timer: frame counter plus tick generation, parameterised by STEP_FRAMES/CNT_BITS.
- Synchronizers and FSM stay in tbird_seq.

Test Plan:
- Reset: assert clr mid-sweep at L3 -> pattern=3FFFFF, state_dbg=0, step=0 immediately, asynchronously, without a clock edge.
- STEP_FRAMES=2, left_sw=1 held, 12 frame_start pulses -> patterns on ticks: 3FE7FF, 3F07FF, 3807FF, 2007FF, 0007FF, 3FFFFF, then repeat. One step pulse per 2 frames.
- right_sw=1 held -> 3FF9FF, 3FF83F, 3FF807, 3FF801, 3FF800, 3FFFFF. Then both left and right on -> 000000/3FFFFF alternating after passing through OFF.
- Left held to L2, then switch to right before next tick -> next tick 3FFFFF (OFF), following tick 3FF9FF (R1).
- haz_sw=1 from OFF -> 000000, 3FFFFF, 000000. Release haz_sw -> next tick 3FFFFF and stays there; no pattern change between frame_start pulses at any time.
- Pulse left_sw for 3 cycles between ticks -> no state change. frame_start absent for 1000 cycles -> counter and pattern frozen.

Source files
------------

// File: rtl/tbird_pkg.sv
// Shared constants and types for the tail-light sequencer: lamp codes,
// state encoding, request decode and the state-to-lamp mapping.
package tbird_pkg;

  localparam int PAT_W = 22;

  // Active-low lamp codes driven to the bit generator
  localparam logic [PAT_W-1:0] PAT_O  = 22'h3FFFFF;
  localparam logic [PAT_W-1:0] PAT_H  = 22'h000000;
  localparam logic [PAT_W-1:0] PAT_L1 = 22'h3FE7FF;
  localparam logic [PAT_W-1:0] PAT_L2 = 22'h3F07FF;
  localparam logic [PAT_W-1:0] PAT_L3 = 22'h3807FF;
  localparam logic [PAT_W-1:0] PAT_L4 = 22'h2007FF;
  localparam logic [PAT_W-1:0] PAT_L5 = 22'h0007FF;
  localparam logic [PAT_W-1:0] PAT_R1 = 22'h3FF9FF;
  localparam logic [PAT_W-1:0] PAT_R2 = 22'h3FF83F;
  localparam logic [PAT_W-1:0] PAT_R3 = 22'h3FF807;
  localparam logic [PAT_W-1:0] PAT_R4 = 22'h3FF801;
  localparam logic [PAT_W-1:0] PAT_R5 = 22'h3FF800;

  // Encoding is visible on the debug LEDs, so values are fixed
  typedef enum logic [3:0] {
    ST_OFF  = 4'd0,
    ST_L1   = 4'd1,
    ST_L2   = 4'd2,
    ST_L3   = 4'd3,
    ST_L4   = 4'd4,
    ST_L5   = 4'd5,
    ST_R1   = 4'd6,
    ST_R2   = 4'd7,
    ST_R3   = 4'd8,
    ST_R4   = 4'd9,
    ST_R5   = 4'd10,
    ST_HON  = 4'd11,
    ST_HOFF = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_HAZ   = 2'd3
  } req_t;

  // Hazard wins; both directions at once is treated as hazard
  function automatic req_t decode_req(input logic haz, input logic left,
                                      input logic right);
    req_t rq;
    if (haz || (left && right)) rq = REQ_HAZ;
    else if (left)              rq = REQ_LEFT;
    else if (right)             rq = REQ_RIGHT;
    else                        rq = REQ_NONE;
    return rq;
  endfunction

  function automatic logic [PAT_W-1:0] state_pattern(input state_t st);
    logic [PAT_W-1:0] p;
    case (st)
      ST_L1:   p = PAT_L1;
      ST_L2:   p = PAT_L2;
      ST_L3:   p = PAT_L3;
      ST_L4:   p = PAT_L4;
      ST_L5:   p = PAT_L5;
      ST_R1:   p = PAT_R1;
      ST_R2:   p = PAT_R2;
      ST_R3:   p = PAT_R3;
      ST_R4:   p = PAT_R4;
      ST_R5:   p = PAT_R5;
      ST_HON:  p = PAT_H;
      default: p = PAT_O;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Frame counter: produces a one-cycle tick on every STEP_FRAMES-th
// frame_start pulse. The counter is frozen while frame_start is idle.
module step_timer #(
  parameter int STEP_FRAMES = 15,
  parameter int CNT_BITS    = 6
) (
  input  logic clk,
  input  logic clr,
  input  logic frame_start,
  output logic tick
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(STEP_FRAMES - 1);

  logic [CNT_BITS-1:0] frame_cnt;

  // Tick coincides with the frame_start that wraps the counter
  assign tick = frame_start && (frame_cnt == LAST);

  // Count frame_start pulses, wrapping at STEP_FRAMES-1
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      if (frame_cnt == LAST) frame_cnt <= '0;
      else                   frame_cnt <= frame_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/tbird_seq.sv
// Tail-light sequencer: synchronises the switch requests and steps the
// lamp FSM once per animation tick so the pattern only changes at a
// frame boundary.
module tbird_seq
  import tbird_pkg::*;
#(
  parameter int STEP_FRAMES = 15,
  parameter int CNT_BITS    = 6
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              left_sw,
  input  logic              right_sw,
  input  logic              haz_sw,
  input  logic              frame_start,
  output logic [PAT_W-1:0]  pattern,
  output logic              step,
  output logic [3:0]        state_dbg
);

  // Sweep sequencing: a sweep only continues while its own request holds
  function automatic state_t next_state(input state_t st, input req_t rq);
    state_t nxt;
    case (st)
      ST_OFF: begin
        case (rq)
          REQ_HAZ:   nxt = ST_HON;
          REQ_LEFT:  nxt = ST_L1;
          REQ_RIGHT: nxt = ST_R1;
          default:   nxt = ST_OFF;
        endcase
      end
      ST_L1:   nxt = (rq == REQ_LEFT)  ? ST_L2 : ST_OFF;
      ST_L2:   nxt = (rq == REQ_LEFT)  ? ST_L3 : ST_OFF;
      ST_L3:   nxt = (rq == REQ_LEFT)  ? ST_L4 : ST_OFF;
      ST_L4:   nxt = (rq == REQ_LEFT)  ? ST_L5 : ST_OFF;
      ST_R1:   nxt = (rq == REQ_RIGHT) ? ST_R2 : ST_OFF;
      ST_R2:   nxt = (rq == REQ_RIGHT) ? ST_R3 : ST_OFF;
      ST_R3:   nxt = (rq == REQ_RIGHT) ? ST_R4 : ST_OFF;
      ST_R4:   nxt = (rq == REQ_RIGHT) ? ST_R5 : ST_OFF;
      ST_HON:  nxt = (rq == REQ_HAZ)   ? ST_HOFF : ST_OFF;
      ST_HOFF: nxt = (rq == REQ_HAZ)   ? ST_HON  : ST_OFF;
      default: nxt = ST_OFF;  // L5, R5: one dark step between sweeps
    endcase
    return nxt;
  endfunction

  // Switch bits packed as {haz, left, right}
  logic [2:0] sw_p0;
  logic [2:0] sw_p1;
  logic       tick;
  req_t       req;
  state_t     state;
  state_t     state_nxt;

  // Two-flop synchronisers for the asynchronous board switches
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= {haz_sw, left_sw, right_sw};
      sw_p1 <= sw_p0;
    end
  end

  step_timer #(
    .STEP_FRAMES (STEP_FRAMES),
    .CNT_BITS    (CNT_BITS)
  ) u_timer (
    .clk         (clk),
    .clr         (clr),
    .frame_start (frame_start),
    .tick        (tick)
  );

  // Request decode and next-state selection from synchronised switches
  always_comb begin
    req       = decode_req(sw_p1[2], sw_p1[1], sw_p1[0]);
    state_nxt = next_state(state, req);
  end

  // FSM with registered pattern and step pulse, advanced only on tick
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_OFF;
      pattern <= PAT_O;
      step    <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        state   <= state_nxt;
        pattern <= state_pattern(state_nxt);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tbird_seq.sv
// Self-checking bench for tbird_seq: two instances (STEP_FRAMES=2 and 1)
// driven by the same switches, compared against a sweep-level model.
module tb_tbird_seq;

  logic        clk;
  logic        clr;
  logic        left_sw;
  logic        right_sw;
  logic        haz_sw;
  logic        frame_start;
  logic [21:0] pattern0, pattern1;
  logic        step0, step1;
  logic [3:0]  dbg0, dbg1;

  tbird_seq #(.STEP_FRAMES(2), .CNT_BITS(6)) dut0 (
    .clk(clk), .clr(clr), .left_sw(left_sw), .right_sw(right_sw),
    .haz_sw(haz_sw), .frame_start(frame_start),
    .pattern(pattern0), .step(step0), .state_dbg(dbg0)
  );

  tbird_seq #(.STEP_FRAMES(1), .CNT_BITS(1)) dut1 (
    .clk(clk), .clr(clr), .left_sw(left_sw), .right_sw(right_sw),
    .haz_sw(haz_sw), .frame_start(frame_start),
    .pattern(pattern1), .step(step1), .state_dbg(dbg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_OFF   = 0;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_HON   = 3;
  localparam int K_HOFF  = 4;

  int errors = 0;
  int checks = 0;
  int m_kind [2];
  int m_n    [2];
  int m_cnt  [2];
  int m_sf   [2];
  bit m_tick [2];
  logic [21:0] lmask [6];

  function automatic logic [21:0] mirror(input logic [21:0] v);
    logic [21:0] r;
    for (int b = 0; b < 22; b++) r[b] = v[21-b];
    return r;
  endfunction

  function automatic logic [21:0] exp_pat(input int i);
    case (m_kind[i])
      K_LEFT:  return ~lmask[m_n[i]];
      K_RIGHT: return ~mirror(lmask[m_n[i]]);
      K_HON:   return 22'h000000;
      default: return 22'h3FFFFF;
    endcase
  endfunction

  function automatic int exp_dbg(input int i);
    case (m_kind[i])
      K_LEFT:  return m_n[i];
      K_RIGHT: return 5 + m_n[i];
      K_HON:   return 11;
      K_HOFF:  return 12;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = K_OFF;
      m_n[i]    = 0;
      m_cnt[i]  = 0;
      m_tick[i] = 1'b0;
    end
  endtask

  task automatic model_tick(input int i, input bit haz, input bit l, input bit r);
    int rq;
    if (haz || (l && r)) rq = 3;
    else if (l)          rq = 1;
    else if (r)          rq = 2;
    else                 rq = 0;
    case (m_kind[i])
      K_OFF: begin
        if (rq == 3)      m_kind[i] = K_HON;
        else if (rq == 1) begin m_kind[i] = K_LEFT;  m_n[i] = 1; end
        else if (rq == 2) begin m_kind[i] = K_RIGHT; m_n[i] = 1; end
      end
      K_LEFT:  if (rq == 1 && m_n[i] < 5) m_n[i]++; else m_kind[i] = K_OFF;
      K_RIGHT: if (rq == 2 && m_n[i] < 5) m_n[i]++; else m_kind[i] = K_OFF;
      K_HON:   m_kind[i] = (rq == 3) ? K_HOFF : K_OFF;
      default: m_kind[i] = (rq == 3) ? K_HON  : K_OFF;
    endcase
  endtask

  task automatic check_all(input bit exp_step0, input bit exp_step1);
    chk("pattern0", pattern0, exp_pat(0));
    chk("pattern1", pattern1, exp_pat(1));
    chk("step0", step0, exp_step0);
    chk("step1", step1, exp_step1);
    chk("dbg0", dbg0, exp_dbg(0));
    chk("dbg1", dbg1, exp_dbg(1));
  endtask

  // Idle cycles: nothing may change between frame_start pulses
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("hold_pattern0", pattern0, exp_pat(0));
      chk("hold_pattern1", pattern1, exp_pat(1));
      chk("hold_step0", step0, 1'b0);
      chk("hold_step1", step1, 1'b0);
    end
  endtask

  // One frame_start pulse after gap idle cycles, then check the result
  task automatic frame(input int gap);
    idle(gap);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = (m_cnt[i] == m_sf[i] - 1);
      m_cnt[i]  = m_tick[i] ? 0 : m_cnt[i] + 1;
      if (m_tick[i]) model_tick(i, haz_sw, left_sw, right_sw);
    end
    check_all(m_tick[0], m_tick[1]);
  endtask

  task automatic set_sw(input bit l, input bit r, input bit h);
    left_sw  = l;
    right_sw = r;
    haz_sw   = h;
  endtask

  initial begin
    m_sf[0] = 2;
    m_sf[1] = 1;
    lmask[0] = 22'h000000;
    lmask[1] = 22'h001800;
    lmask[2] = 22'h00F800;
    lmask[3] = 22'h07F800;
    lmask[4] = 22'h1FF800;
    lmask[5] = 22'h3FF800;
    model_reset();
    clr = 1'b1;
    frame_start = 1'b0;
    set_sw(0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all(0, 0);
    chk("reset_pattern_const", pattern0, 32'h003FFFFF);
    clr = 1'b0;

    // Left sweep held over 12 frames
    set_sw(1, 0, 0);
    for (int k = 0; k < 12; k++) frame(3);

    // Right sweep, then both directions acting as hazard
    set_sw(0, 1, 0);
    for (int k = 0; k < 12; k++) frame(3);
    set_sw(1, 1, 0);
    for (int k = 0; k < 8; k++) frame(3);

    // Left to L2, then switch to right: must pass through OFF
    set_sw(0, 0, 0);
    for (int k = 0; k < 4; k++) frame(3);
    set_sw(1, 0, 0);
    for (int k = 0; k < 20 && !(m_kind[0] == K_LEFT && m_n[0] == 2); k++) frame(3);
    chk("reach_L2", dbg0, 4'd2);
    set_sw(0, 1, 0);
    for (int k = 0; k < 4; k++) frame(3);

    // Hazard from OFF, then release
    set_sw(0, 0, 0);
    for (int k = 0; k < 4; k++) frame(3);
    set_sw(0, 0, 1);
    for (int k = 0; k < 6; k++) frame(3);
    set_sw(0, 0, 0);
    for (int k = 0; k < 4; k++) frame(3);

    // Short left pulse between frames is ignored
    set_sw(1, 0, 0);
    idle(3);
    set_sw(0, 0, 0);
    for (int k = 0; k < 2; k++) frame(4);

    // Long gap without frame_start: everything frozen
    frame(3);
    idle(1000);
    for (int k = 0; k < 3; k++) frame(3);

    // Asynchronous clear mid-sweep at L3
    set_sw(1, 0, 0);
    for (int k = 0; k < 20 && !(m_kind[0] == K_LEFT && m_n[0] == 3); k++) frame(3);
    chk("reach_L3", dbg0, 4'd3);
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all(0, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < 3; k++) frame(3);

    // Clear and frame_start together: clear wins, counter stays at 0
    @(posedge clk); #1;
    clr = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    model_reset();
    check_all(0, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < 4; k++) frame(3);

    // Randomised switch activity
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0)
        set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 5) == 0));
      frame($urandom_range(3, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
